// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART serial path (transmitter now, receiver later).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_serial_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO on an inferred RAM with a registered read port.
// rdata shows the head entry one cycle after it was written or became the head.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     gclk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_ok;
    logic             pop_ok;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = rdata_reg;
    assign count   = count_reg;

    always_ff @(posedge gclk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
        rdata_reg <= mem[rd_ptr_reg];
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_serial_tx.sv
// Byte-FIFO-fed UART transmitter, 8N1/8N2 LSB first.
// Define UART_SERIAL_TX_PARITY_EN to insert an even-parity bit (8E1/8E2).
module uart_serial_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int FIFO_DEPTH  = 16,
    parameter int STOP_BITS   = 1
) (
    input  logic                          gclk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int DIV      = baud_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CNT_W    = $clog2(STOP_LEN);
    localparam int IDX_W    = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(UART_DATA_BITS - 1);

    if (DIV < 2) begin : g_div_chk
        $error("uart_serial_tx: CLK_FREQ_HZ/BAUD_RATE gives fewer than 2 cycles per bit");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
        $error("uart_serial_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_t         state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [7:0]        shift_reg;
    logic [IDX_W-1:0]  bit_idx_reg;
    logic              txd_reg;
    logic              head_ok_reg;
`ifdef UART_SERIAL_TX_PARITY_EN
    logic              parity_reg;
`endif

    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       bit_end;
    logic       pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .gclk  (gclk),
        .rst_n (rst_n),
        .push  (tx_valid),
        .pop   (pop),
        .wdata (tx_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_ready = ~fifo_full;
    assign txd      = txd_reg;
    assign busy     = (state_reg != IDLE) | (fifo_count != '0);
    assign bit_end  = (cnt_reg == '0);

    // The FIFO read port is registered, so a head entry is only trusted once
    // it has been sitting there for a full cycle (head_ok_reg).
    assign pop = head_ok_reg & ~fifo_empty &
                 ((state_reg == IDLE) | ((state_reg == STOP) & bit_end));

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            txd_reg     <= 1'b1;
            head_ok_reg <= 1'b0;
`ifdef UART_SERIAL_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            head_ok_reg <= ~fifo_empty & ~pop;
            case (state_reg)
                IDLE: begin
                    txd_reg <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        state_reg   <= DATA;
                        cnt_reg     <= BIT_LOAD;
                        bit_idx_reg <= '0;
                        txd_reg     <= shift_reg[0];
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_reg == LAST_IDX) begin
`ifdef UART_SERIAL_TX_PARITY_EN
                            state_reg <= PARITY;
                            cnt_reg   <= BIT_LOAD;
                            txd_reg   <= parity_reg;
`else
                            state_reg <= STOP;
                            cnt_reg   <= STOP_LOAD;
                            txd_reg   <= 1'b1;
`endif
                        end else begin
                            cnt_reg     <= BIT_LOAD;
                            shift_reg   <= shift_reg >> 1;
                            bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                            txd_reg     <= shift_reg[1];
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
`ifdef UART_SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_reg <= STOP;
                        cnt_reg   <= STOP_LOAD;
                        txd_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    txd_reg   <= 1'b1;
                end
            endcase

            // Frame launch overrides the IDLE/STOP defaults above.
            if (pop) begin
                state_reg <= START;
                cnt_reg   <= BIT_LOAD;
                shift_reg <= fifo_rdata;
                txd_reg   <= 1'b0;
`ifdef UART_SERIAL_TX_PARITY_EN
                parity_reg <= ^fifo_rdata;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_serial_tx.sv
// Bench for uart_serial_tx: table-driven frame vectors, timed corner sequences,
// and random traffic decoded by a UART monitor against a byte queue.
module tb_uart_serial_tx;
    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = 10;
    localparam int DEPTH  = 16;
`ifdef UART_SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       gclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, txd, busy;
    logic [4:0] fifo_count;
    logic [7:0] tx_data2 = 8'h00;
    logic       tx_valid2 = 1'b0;
    logic       tx_ready2, txd2, busy2;
    logic [4:0] fifo_count2;

    always #5 gclk = ~gclk;

    uart_serial_tx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
        .gclk(gclk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .txd(txd), .busy(busy), .fifo_count(fifo_count));

    uart_serial_tx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
        .gclk(gclk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .txd(txd2), .busy(busy2), .fifo_count(fifo_count2));

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    int  rx_count = 0;
    bit  mon_en = 1'b0;
    int  peak = 0;

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq;   // expected data bits in line order, seq[7] sent first
        logic       par;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge gclk);
        #1;
    endtask

    // Scoreboard: every accepted byte is queued for the monitor.
    always @(posedge gclk) begin
        if (rst_n && tx_valid && tx_ready) exp_q.push_back(tx_data);
    end

    always @(negedge gclk) begin
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end

    // UART monitor: mid-bit sampling of dut.txd.
    initial begin : monitor
        logic       smp[12];
        logic [7:0] rb;
        logic [7:0] eb;
        bit         ok;
        forever begin
            @(negedge gclk);
            if (mon_en && rst_n && txd === 1'b0) begin
                ok = 1'b1;
                for (int b = 0; b < 10 + PAR && ok; b++) begin
                    for (int k = 0; k < ((b == 0) ? DIV / 2 : DIV); k++) begin
                        @(negedge gclk);
                        if (!mon_en) begin
                            ok = 1'b0;
                            break;
                        end
                    end
                    if (ok) smp[b] = txd;
                end
                if (ok) begin
                    for (int i = 0; i < 8; i++) rb[i] = smp[i + 1];
                    check("mon_start", smp[0], 0);
                    check("mon_stop", smp[9 + PAR], 1);
                    if (exp_q.size() == 0) begin
                        check("mon_unexpected_byte", 1, 0);
                    end else begin
                        eb = exp_q.pop_front();
                        check("mon_data", rb, eb);
`ifdef UART_SERIAL_TX_PARITY_EN
                        check("mon_parity", smp[9], ^eb);
`endif
                    end
                    rx_count++;
                end
            end
        end
    end

    // Called right after the edge where txd is expected to go low.
    task automatic frame_check(input logic [7:0] seq, input logic par, input int stops, input bit sel);
        int  nbits;
        int  bad;
        int  idle;
        logic e;
        nbits = 9 + PAR + stops;
        for (int p = 0; p < nbits; p++) begin
            if (p == 0) e = 1'b0;
            else if (p <= 8) e = seq[8 - p];
            else if (PAR == 1 && p == 9) e = par;
            else e = 1'b1;
            bad = 0;
            idle = 0;
            for (int c = 0; c < DIV; c++) begin
                if ((sel ? txd2 : txd) !== e) bad++;
                if ((sel ? busy2 : busy) !== 1'b1) idle++;
                step();
            end
            check($sformatf("frame_bit%0d_bad_cycles", p), bad, 0);
            check($sformatf("frame_bit%0d_busy_low", p), idle, 0);
        end
    endtask

    task automatic send_one(input logic [7:0] b);
        tx_data = b;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        check("lat_n0_txd", txd, 1);
        check("lat_n0_count", fifo_count, 1);
        step();
        check("lat_n1_txd", txd, 1);
        check("lat_n1_count", fifo_count, 1);
        step();
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin
            step();
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    initial begin : main
        int snap;
        int acc_n;
        int cyc;
        bit acc;
        logic [7:0] hold_bytes[20];

        vecs[0] = '{8'h55, 8'b10101010, 1'b0};
        vecs[1] = '{8'h00, 8'b00000000, 1'b0};
        vecs[2] = '{8'hFF, 8'b11111111, 1'b0};
        vecs[3] = '{8'hA3, 8'b11000101, 1'b0};
        vecs[4] = '{8'h07, 8'b11100000, 1'b1};
        vecs[5] = '{8'h03, 8'b11000000, 1'b0};
        vecs[6] = '{8'h3C, 8'b00111100, 1'b0};
        vecs[7] = '{8'h01, 8'b10000000, 1'b1};

        // Reset state
        repeat (3) step();
        check("rst_txd", txd, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst2_txd", txd2, 1);
        check("rst2_busy", busy2, 0);
        rst_n = 1'b1;
        step();
        step();
        mon_en = 1'b1;

        // Single frames from idle, exact timing
        for (int i = 0; i < 8; i++) begin
            $display("vec %0d: byte %02h", i, vecs[i].data);
            send_one(vecs[i].data);
            frame_check(vecs[i].seq, vecs[i].par, 1, 1'b0);
            check("vec_busy_end", busy, 0);
            check("vec_txd_end", txd, 1);
            step();
        end
        check("vec_rx_count", rx_count, 8);

        // Burst of three consecutive pushes, frames back-to-back
        peak = 0;
        tx_valid = 1'b1;
        tx_data = 8'h00; step(); check("burst_count0", fifo_count, 1);
        tx_data = 8'hFF; step(); check("burst_count1", fifo_count, 2);
        tx_data = 8'hA3; step(); check("burst_count2", fifo_count, 2);
        tx_valid = 1'b0;
        frame_check(8'b00000000, 1'b0, 1, 1'b0);
        frame_check(8'b11111111, 1'b0, 1, 1'b0);
        frame_check(8'b11000101, 1'b0, 1, 1'b0);
        check("burst_busy_end", busy, 0);
        check("burst_peak", peak, 2);
        $display("burst: peak fifo_count %0d", peak);

        // Hold tx_valid with 20 distinct bytes
        peak = 0;
        snap = rx_count;
        for (int i = 0; i < 20; i++) hold_bytes[i] = 8'(8'h10 + i * 7);
        acc_n = 0;
        cyc = 0;
        tx_valid = 1'b1;
        while (acc_n < 20 && cyc < 4000) begin
            tx_data = hold_bytes[acc_n];
            acc = tx_ready;
            step();
            cyc++;
            if (acc) begin
                acc_n++;
                if (acc_n == 17) begin
                    check("hold_full_count", fifo_count, 16);
                    check("hold_ready_low", tx_ready, 0);
                end
            end
        end
        tx_valid = 1'b0;
        check("hold_accepted", acc_n, 20);
        wait_idle(5000);
        step();
        check("hold_rx", rx_count - snap, 20);
        check("hold_queue_empty", exp_q.size(), 0);
        check("hold_peak", peak, 16);
        $display("hold: accepted %0d, received %0d, peak %0d", acc_n, rx_count - snap, peak);

        // Reset in the middle of a frame with bytes queued
        tx_valid = 1'b1;
        tx_data = 8'h3C; step();
        tx_data = 8'h11; step();
        tx_data = 8'h22; step();
        tx_data = 8'h33; step();
        tx_valid = 1'b0;
        repeat (20) step();
        check("pre_rst_txd", txd, 0);
        check("pre_rst_count", fifo_count, 3);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_txd", txd, 1);
        check("midrst_count", fifo_count, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", tx_ready, 1);
        repeat (3) step();
        rst_n = 1'b1;
        exp_q.delete();
        step();
        step();
        mon_en = 1'b1;
        step();
        snap = rx_count;
        send_one(8'h7E);
        frame_check(8'b01111110, 1'b0, 1, 1'b0);
        check("postrst_busy_end", busy, 0);
        check("postrst_rx", rx_count - snap, 1);
        $display("reset: 0x7E resent after mid-frame reset");

        // Two stop bits on the second instance
        tx_valid2 = 1'b1;
        tx_data2 = 8'h81; step();
        tx_data2 = 8'h42; step();
        tx_valid2 = 1'b0;
        check("stop2_txd_n1", txd2, 1);
        step();
        frame_check(8'b10000001, 1'b0, 2, 1'b1);
        frame_check(8'b01000010, 1'b0, 2, 1'b1);
        check("stop2_busy_end", busy2, 0);
        $display("stop2: 0x81 then 0x42 with 20-cycle stop");

        // Random traffic with random valid gaps and changing data
        snap = rx_count;
        acc_n = 0;
        cyc = 0;
        while (acc_n < 25 && cyc < 20000) begin
            tx_data = 8'($urandom);
            tx_valid = ($urandom_range(0, 3) == 0);
            acc = tx_valid && tx_ready;
            step();
            cyc++;
            if (acc) acc_n++;
        end
        tx_valid = 1'b0;
        check("rand_accepted", acc_n, 25);
        wait_idle(5000);
        step();
        check("rand_rx", rx_count - snap, 25);
        check("rand_queue_empty", exp_q.size(), 0);
        $display("random: %0d bytes sent, %0d received", acc_n, rx_count - snap);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_serial_tx.md
Name: uart_serial_tx

Overview:
- Byte-oriented UART transmitter for the A7 board's serial path (FPGA → host). Streams SHA3 digest bytes and status text out for checking with host tools such as openssl.
- Accepts bytes over a valid/ready handshake into a small FIFO, then serialises them 8N1, LSB first.
- In the top level, `txd` drives the pin currently looped back as `uart_rx`.

Parameters:
- CLK_FREQ_HZ, 100_000_000, gclk frequency in Hz.
- BAUD_RATE, 115_200, line rate in bit/s.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, minimum 2.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- gclk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  FIFO can accept a byte (not full).
- txd  out  1  serial line out; idle high.
- busy  out  1  a frame is in flight or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently held in the FIFO.

Behaviour:
- Reset (async assert, sync release):
  - txd=1, tx_ready=1, busy=0, fifo_count=0.
  - FSM goes to IDLE; FIFO is emptied; baud counter is cleared.
  - Reset mid-frame aborts the frame; txd returns to 1 immediately.
- Handshake:
  - A byte is accepted on a rising edge where tx_valid & tx_ready.
  - tx_ready = (fifo_count < FIFO_DEPTH) and is combinational from registered state.
  - tx_data is sampled only at acceptance. The sender may drop tx_valid at any time; bytes are never lost or duplicated.
- FIFO:
  - Synchronous FIFO with circular read/write pointers that wrap modulo FIFO_DEPTH.
  - Push and pop on the same edge leave fifo_count unchanged.
  - No push when full (tx_ready=0). No pop when empty.
- Baud timing:
  - DIV = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE, i.e. rounded to nearest.
  - Every bit lasts exactly DIV gclk cycles. The counter runs from DIV-1 down to 0 and reloads on bit change.
  - Elaboration error if DIV < 2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1. If the FIFO is non-empty, pop into the shift register, load the counter, and go to START. This happens on the same edge txd is registered low.
  - START: txd=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: txd = shift[0]. At the end of each bit, shift right and increment the index. After bit 7, go to PARITY (if enabled) or STOP.
  - PARITY: one bit period, only when the feature is enabled.
  - STOP: txd=1 for STOP_BITS×DIV cycles. Then:
    - if the FIFO is non-empty, pop and go straight to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE drives txd low from edge N+2.
- txd is a flop output (glitch-free). busy = (state != IDLE) | (fifo_count != 0).
- Arithmetic: fifo_count is a full-range counter (holds FIFO_DEPTH when full). Pointer widths are $clog2(FIFO_DEPTH).

Optional Feature:
- Macro: UART_SERIAL_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted after bit 7 for one bit period. The frame becomes 8E1, or 8E2 with STOP_BITS=2.
- Undefined: the PARITY state and parity logic are absent; the frame is 8N1 or 8N2.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam UART_DATA_BITS = 8;
  - function baud_div(clk_hz, baud) implementing the rounding rule.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; ports gclk, rst_n, push, pop, wdata, rdata, full, empty, count). It is reusable for a later receiver.

Test Plan (CLK_FREQ_HZ=1_000_000, BAUD_RATE=100_000 → DIV=10, STOP_BITS=1 unless noted):
- Single byte 0x55, FIFO empty:
  - txd low from edge N+2 for 10 cycles;
  - then data bits 1,0,1,0,1,0,1,0 at 10 cycles each;
  - then 1 for 10 cycles;
  - busy falls after 100 cycles of frame.
- Burst 0x00, 0xFF, 0xA3 pushed on consecutive cycles:
  - frames are back-to-back with no idle gap;
  - 0xA3 bits are 1,1,0,0,0,1,0,1;
  - fifo_count peaks at 2.
- Hold tx_valid high with 20 distinct bytes (FIFO_DEPTH=16):
  - tx_ready drops at count 16;
  - all 20 bytes are received in order by a bench UART monitor;
  - fifo_count never exceeds 16.
- Assert rst_n low mid-DATA of 0x3C with 3 bytes queued:
  - txd=1 immediately; fifo_count=0; state IDLE;
  - the next pushed byte 0x7E transmits correctly.
- STOP_BITS=2, byte 0x81: stop high lasts 20 cycles before the next start bit.
- With UART_SERIAL_TX_PARITY_EN:
  - 0x07 gives parity bit 1; 0x03 gives parity bit 0;
  - frame length is 110 cycles.
